// File: rtl/stack_pkg.sv
// Shared constants and request encoding for the operand stack.
// The controller and datapath use the same OP_* names.
package stack_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 16;

  // {push,pop,tos} after priority resolution
  localparam logic [2:0] OP_IDLE = 3'b000;
  localparam logic [2:0] OP_PUSH = 3'b100;
  localparam logic [2:0] OP_POP  = 3'b010;
  localparam logic [2:0] OP_TOS  = 3'b001;
  localparam logic [2:0] OP_REPL = 3'b110;
  localparam logic [2:0] OP_PTOS = 3'b101;

  // Pop dominates tos; push+pop is replace-top whatever tos says.
  function automatic logic [2:0] op_decode(
    input logic push,
    input logic pop,
    input logic tos
  );
    if (push && pop) return OP_REPL;
    if (pop)         return OP_POP;
    if (push && tos) return OP_PTOS;
    if (push)        return OP_PUSH;
    if (tos)         return OP_TOS;
    return OP_IDLE;
  endfunction

endpackage

// File: rtl/stack_ram.sv
// Stack storage: one synchronous write port,
// one combinational read port.
module stack_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [PTR_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [PTR_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Contents are never cleared; only sp decides what is valid.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stack_unit.sv
// LIFO operand stack with registered top-of-stack read,
// occupancy status and sticky overflow/underflow flags.
module stack_unit
  import stack_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              tos,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  output logic [PTR_W:0]    count,
  output logic              empty,
  output logic              full,
  output logic              ovf,
  output logic              unf
);

  localparam logic [PTR_W:0]   SP_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   SP_MAX  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] IDX_ONE = PTR_W'(1);

  logic [PTR_W:0]    sp_q, sp_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic [2:0]        op;
  logic              we;
  logic [PTR_W-1:0]  waddr;
  logic [PTR_W-1:0]  top_idx;
  logic [DATA_W-1:0] top;

  assign op      = op_decode(push, pop, tos);
  assign empty   = (sp_q == '0);
  assign full    = (sp_q == SP_MAX);
  assign top_idx = sp_q[PTR_W-1:0] - IDX_ONE;

  stack_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (d_in),
    .raddr_i (top_idx),
    .rdata_o (top)
  );

  // Next state for pointer, read register and error flags.
  always_comb begin
    sp_d   = sp_q;
    dout_d = dout_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    we     = 1'b0;
    waddr  = sp_q[PTR_W-1:0];
    unique case (op)
      OP_PUSH: begin
        if (full) ovf_d = 1'b1;
        else begin
          we   = 1'b1;
          sp_d = sp_q + SP_ONE;
        end
      end
      OP_POP: begin
        if (empty) unf_d = 1'b1;
        else begin
          dout_d = top;
          sp_d   = sp_q - SP_ONE;
        end
      end
      OP_TOS: begin
        if (empty) unf_d = 1'b1;
        else dout_d = top;
      end
      OP_REPL: begin
        we = 1'b1;
        if (empty) begin
          unf_d = 1'b1;
          sp_d  = sp_q + SP_ONE;
        end else begin
          dout_d = top;
          waddr  = top_idx;
        end
      end
      OP_PTOS: begin
        if (empty) unf_d = 1'b1;
        else dout_d = top;
        if (full) ovf_d = 1'b1;
        else begin
          we   = 1'b1;
          sp_d = sp_q + SP_ONE;
        end
      end
      default: ;
    endcase
  end

  // State registers; reset wins over any request.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q   <= '0;
      dout_q <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      sp_q   <= sp_d;
      dout_q <= dout_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  assign count = sp_q;
  assign d_out = dout_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule

// File: tb/tb_stack_unit.sv
// Bench for stack_unit: directed scenarios plus random traffic,
// checked against a queue-based stack model via a scoreboard.
module tb_stack_unit;

  localparam int DW = 8;
  localparam int DP = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic          tos = 1'b0;
  logic [DW-1:0] d_in = '0;
  logic [DW-1:0] d_out;
  logic [4:0]    count;
  logic          empty, full, ovf, unf;

  stack_unit #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .tos   (tos),
    .d_in  (d_in),
    .d_out (d_out),
    .count (count),
    .empty (empty),
    .full  (full),
    .ovf   (ovf),
    .unf   (unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    cnt;
    int    dout;
    bit    e;
    bit    f;
    bit    o;
    bit    u;
    string name;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int m_stk[$];
  int m_dout = 0;
  bit m_ovf = 0;
  bit m_unf = 0;

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Behavioural stack semantics applied to one clock edge.
  task automatic model(input bit r, input bit p, input bit o,
                       input bit t, input int d);
    if (r) begin
      m_stk.delete();
      m_dout = 0;
      m_ovf = 0;
      m_unf = 0;
    end else if (p && o) begin
      if (m_stk.size() == 0) begin
        m_unf = 1;
        m_stk.push_back(d);
      end else begin
        m_dout = m_stk[m_stk.size()-1];
        m_stk[m_stk.size()-1] = d;
      end
    end else if (o) begin
      if (m_stk.size() == 0) m_unf = 1;
      else m_dout = m_stk.pop_back();
    end else if (p) begin
      if (t) begin
        if (m_stk.size() == 0) m_unf = 1;
        else m_dout = m_stk[m_stk.size()-1];
      end
      if (m_stk.size() == DP) m_ovf = 1;
      else m_stk.push_back(d);
    end else if (t) begin
      if (m_stk.size() == 0) m_unf = 1;
      else m_dout = m_stk[m_stk.size()-1];
    end
  endtask

  task automatic step(input bit r, input bit p, input bit o,
                      input bit t, input int d, input string nm);
    exp_t x;
    @(negedge clk);
    rst  = r;
    push = p;
    pop  = o;
    tos  = t;
    d_in = DW'(d);
    model(r, p, o, t, d);
    x.cnt  = m_stk.size();
    x.dout = m_dout;
    x.e    = (m_stk.size() == 0);
    x.f    = (m_stk.size() == DP);
    x.o    = m_ovf;
    x.u    = m_unf;
    x.name = nm;
    sb.push_back(x);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, "idle");
  endtask

  // Monitor: every edge retires one expected response.
  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        x = sb.pop_front();
        chk({x.name, ".count"}, int'(count), x.cnt);
        chk({x.name, ".d_out"}, int'(d_out), x.dout);
        chk({x.name, ".empty"}, int'(empty), int'(x.e));
        chk({x.name, ".full"},  int'(full),  int'(x.f));
        chk({x.name, ".ovf"},   int'(ovf),   int'(x.o));
        chk({x.name, ".unf"},   int'(unf),   int'(x.u));
      end
    end
  end

  initial begin : driver
    int r;
    step(1, 0, 0, 0, 0, "reset");
    step(1, 0, 0, 0, 0, "reset");
    // LIFO order and tos
    step(0, 1, 0, 0, 'h11, "t1.push");
    step(0, 1, 0, 0, 'h22, "t1.push");
    step(0, 1, 0, 0, 'h33, "t1.push");
    step(0, 0, 0, 1, 0, "t1.tos");
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, "t1.pop");
    // underflow from empty
    step(0, 0, 1, 0, 0, "t3.pop_empty");
    step(0, 0, 0, 1, 0, "t3.tos_empty");
    idle();
    // fill, overflow
    step(1, 0, 0, 0, 0, "t2.reset");
    for (int i = 0; i < DP; i++) step(0, 1, 0, 0, i, "t2.fill");
    step(0, 1, 0, 0, 'hAA, "t2.push_full");
    step(0, 0, 1, 0, 0, "t2.pop");
    // replace-top
    step(1, 0, 0, 0, 0, "t4.reset");
    step(0, 1, 0, 0, 'h05, "t4.push");
    step(0, 1, 0, 0, 'h07, "t4.push");
    step(0, 1, 1, 0, 'h09, "t4.repl");
    step(0, 0, 1, 0, 0, "t4.pop");
    step(0, 0, 1, 0, 0, "t4.pop");
    // push+tos
    step(1, 0, 0, 0, 0, "t5.reset");
    step(0, 1, 0, 0, 'h42, "t5.push");
    step(0, 1, 0, 1, 'h43, "t5.ptos");
    step(0, 0, 0, 1, 0, "t5.tos");
    // reset beats push
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, i + 1, "t6.push");
    step(1, 1, 0, 0, 'h77, "t6.rst_push");
    step(0, 0, 1, 0, 0, "t6.pop");
    // random traffic, push-biased bursts to hit full
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r == 0) step(1, 0, 0, 0, 0, "rnd.reset");
      else if ((i / 200) % 2 == 0)
        step(0, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 2,
             $urandom_range(0, 9) < 3, int'($urandom_range(0, 255)),
             "rnd.fill");
      else
        step(0, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 5,
             $urandom_range(0, 9) < 3, int'($urandom_range(0, 255)),
             "rnd.drain");
    end
    idle();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d left expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
